timer_sched: RTL and testbench
==============================

TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one timer.
REQ-002 Parameter CW, default 4: width of each requester's period-count field.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 R_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ  input  NREQ  level request per requester; held until DONE or withdrawn to abort.
REQ-006 CNT  input  NREQ*CW  timer periods wanted per requester; slice i = CNT[i*CW +: CW].
REQ-007 POUT_ONE  input  1  one-cycle expiry pulse from the shared timer.
REQ-008 TRG_ONE  output  1  one-cycle start pulse to the timer.
REQ-009 MODE  output  1  timer restart-on-trigger select; constant 1.
REQ-010 TMR_R  output  1  synchronous active-high clear to the timer, one-cycle pulse.
REQ-011 GNT  output  NREQ  one-hot grant, or all-zero.
REQ-012 DONE  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-013 BUSY  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT, FIN, ABORT; the state, GNT, DONE and the remaining-count register SHALL be registered.
REQ-015 In IDLE with any REQ bit high, the block SHALL select the first requester at or after index (last+1) mod NREQ, register its index, load remaining = CNT slice (0 treated as 1), set GNT one-hot, and go to START.
REQ-016 Latency: REQ sampled high at edge k -> GNT high after edge k, TRG_ONE high for the cycle after edge k.
REQ-017 START: TRG_ONE=1 for exactly one cycle, then WAIT unconditionally.
REQ-018 WAIT: each POUT_ONE with remaining>1 decrements remaining; no retrigger (timer free-runs its period).
REQ-019 WAIT: POUT_ONE with remaining==1 -> FIN.
REQ-020 FIN: DONE[idx]=1 for one cycle, GNT cleared, last=idx, -> IDLE.
REQ-021 WAIT with REQ[idx] low and no final POUT_ONE -> ABORT; ABORT pulses TMR_R one cycle, no DONE, GNT cleared, last=idx, -> IDLE.
REQ-022 Final POUT_ONE and REQ[idx] deassertion in the same cycle: completion wins (FIN, DONE issued).
REQ-023 POUT_ONE outside WAIT SHALL be ignored.
REQ-024 REQ/CNT changes of non-granted requesters during a grant SHALL have no effect; CNT is sampled only at grant.
REQ-025 Round-robin: no requester holding REQ continuously SHALL wait more than NREQ-1 other grants.
REQ-026 remaining SHALL be CW bits and never wrap below 1.

Reset
REQ-027 R_N low SHALL immediately force: state IDLE, GNT=0, DONE=0, TRG_ONE=0, TMR_R=0, BUSY=0, remaining=0, last=NREQ-1 (first grant goes to index 0).
REQ-028 Reset mid-grant SHALL abandon the grant without DONE; the first cycle after release SHALL be IDLE.

Structure
REQ-029 Package timer_sched_pkg SHALL hold the state enumeration and default NREQ/CW constants.
REQ-030 The round-robin picker SHALL be a sub-module rr_pick (inputs: request vector, last index; outputs: valid, index), purely combinational.

Verification (shared timer instantiated with N=8: first POUT_ONE 8 cycles after TRG_ONE, then every 8)
REQ-031 Reset, REQ=0001, CNT[0]=1 -> GNT=0001 next cycle, one TRG_ONE, POUT_ONE at +8, DONE=0001 one cycle later, BUSY low after.
REQ-032 REQ=0010, CNT[1]=3 -> POUT_ONE at +8/+16/+24 after TRG_ONE, single DONE=0010 after the third, no extra TRG_ONE.
REQ-033 REQ=1111 held, all CNT=1 -> grants in order 0001,0010,0100,1000,0001; no overlap.
REQ-034 REQ[2] dropped 3 cycles into WAIT -> ABORT, TMR_R one-cycle pulse, DONE stays 0, next grant to index 3 if requesting.
REQ-035 REQ[0] dropped in the same cycle as its final POUT_ONE -> DONE=0001 issued, TMR_R stays 0.
REQ-036 R_N low mid-WAIT with CNT=5 -> all outputs 0 immediately; after release a new REQ=0001 gets a fresh grant with no stale DONE.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: FSM states, default sizing
// and the index-width helper used by the top and the round-robin picker.
package timer_sched_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned CW_DEF   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_FIN,
        ST_ABORT
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        if (n > 1) return $clog2(n);
        return 1;
    endfunction

endpackage

// File: rtl/timer_sched_if.sv
// Requester/timer-side bundle of the timer scheduler; master drives requests
// and the timer expiry, slave (the scheduler) drives grants and timer control.
interface timer_sched_if
    import timer_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned CW   = CW_DEF
);

    logic [NREQ-1:0]    REQ;
    logic [NREQ*CW-1:0] CNT;
    logic               POUT_ONE;
    logic               TRG_ONE;
    logic               MODE;
    logic               TMR_R;
    logic [NREQ-1:0]    GNT;
    logic [NREQ-1:0]    DONE;
    logic               BUSY;

    modport master (
        output REQ, CNT, POUT_ONE,
        input  TRG_ONE, MODE, TMR_R, GNT, DONE, BUSY
    );

    modport slave (
        input  REQ, CNT, POUT_ONE,
        output TRG_ONE, MODE, TMR_R, GNT, DONE, BUSY
    );

endinterface

// File: rtl/timer_sched_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// the last-served index, wrapping modulo NREQ.
module rr_pick
    import timer_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Scan last+1 .. last+NREQ so the last-served requester ranks lowest.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(last_i) + i) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// Shares one restartable timer among NREQ requesters: round-robin grant,
// one trigger per grant, counts expiries down to completion or abort.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned CW   = CW_DEF
) (
    input  logic         CLK,
    input  logic         R_N,
    timer_sched_if.slave bus
);

    localparam int unsigned IW = idx_w(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [CW-1:0]   cnt_sel;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i   (bus.REQ),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign cnt_sel = bus.CNT[32'(pick_idx) * CW +: CW];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        rem_d   = rem_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d           = pick_idx;
                    rem_d           = (cnt_sel == '0) ? CW'(1) : cnt_sel;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                // Final expiry outranks a same-cycle withdrawal.
                if (bus.POUT_ONE && rem_q == CW'(1)) begin
                    done_d[idx_q] = 1'b1;
                    gnt_d         = '0;
                    state_d       = ST_FIN;
                end else if (!bus.REQ[idx_q]) begin
                    gnt_d   = '0;
                    state_d = ST_ABORT;
                end else if (bus.POUT_ONE) begin
                    rem_d = rem_q - CW'(1);
                end
            end
            ST_FIN, ST_ABORT: begin
                last_d  = idx_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            rem_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.TRG_ONE = (state_q == ST_START);
    assign bus.TMR_R   = (state_q == ST_ABORT);
    assign bus.BUSY    = (state_q != ST_IDLE);
    assign bus.MODE    = 1'b1;
    assign bus.GNT     = gnt_q;
    assign bus.DONE    = done_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a behavioural period-8 restartable timer.
module tb_timer_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 4;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] cnt;
        int          drop_at;
        int          pout_at;
        logic [3:0]  exp_gnt;
        int          exp_trg;
        logic [3:0]  exp_done;
        int          exp_dcnt;
        int          exp_tmr;
        int          exp_len;
    } vec_t;

    logic CLK = 1'b0;
    logic R_N = 1'b0;
    always #5 CLK = ~CLK;

    timer_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

    timer_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .CLK (CLK),
        .R_N (R_N),
        .bus (bus)
    );

    // Timer: first expiry 8 cycles after the trigger cycle, then every 8.
    logic       t_run;
    logic [3:0] t_cnt;
    logic       pout_inj;

    always @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            t_run <= 1'b0;
            t_cnt <= '0;
        end else if (bus.TMR_R) begin
            t_run <= 1'b0;
            t_cnt <= '0;
        end else if (bus.TRG_ONE) begin
            t_run <= 1'b1;
            t_cnt <= 4'd1;
        end else if (t_run) begin
            t_cnt <= (t_cnt == 4'd8) ? 4'd1 : t_cnt + 4'd1;
        end
    end

    assign bus.POUT_ONE = (t_run && t_cnt == 4'd8) || pout_inj;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int         n;
        int         trg;
        int         dcnt;
        int         tmr;
        logic [3:0] dor;
        logic [3:0] g;
        bit         got;
        @(negedge CLK);
        bus.REQ = v.req;
        bus.CNT = v.cnt;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge CLK);
            if (bus.GNT !== 4'b0000) got = 1'b1;
        end
        chk({nm, "_granted"}, 32'(got), 32'd1);
        if (!got) begin
            bus.REQ = '0;
            return;
        end
        g = bus.GNT;
        n = 0; trg = 0; dcnt = 0; tmr = 0; dor = '0;
        while (bus.BUSY === 1'b1 && n < 400) begin
            if (bus.TRG_ONE === 1'b1) trg++;
            if (bus.TMR_R === 1'b1) tmr++;
            if (bus.DONE !== 4'b0000) begin
                dcnt++;
                dor |= bus.DONE;
            end
            if (n == v.drop_at) bus.REQ = bus.REQ & ~g;
            pout_inj = (n == v.pout_at);
            n++;
            @(negedge CLK);
        end
        pout_inj = 1'b0;
        bus.REQ  = '0;
        chk({nm, "_gnt"},  32'(g),    32'(v.exp_gnt));
        chk({nm, "_trg"},  32'(trg),  32'(v.exp_trg));
        chk({nm, "_done"}, 32'(dor),  32'(v.exp_done));
        chk({nm, "_dcnt"}, 32'(dcnt), 32'(v.exp_dcnt));
        chk({nm, "_tmr"},  32'(tmr),  32'(v.exp_tmr));
        chk({nm, "_len"},  32'(n),    32'(v.exp_len));
    endtask

    vec_t       vecs[11];
    vec_t       fresh;
    logic [3:0] rr_exp[5];
    logic [3:0] prev_g;
    int         k;
    bit         overlap;
    bit         got;

    initial begin
        bus.REQ  = '0;
        bus.CNT  = '0;
        pout_inj = 1'b0;

        // Fields: req, cnt, drop_at, pout_at, gnt, trg, done, dcnt, tmr, len
        vecs[0]  = '{4'b0001, 16'hFFF1, -1, -1, 4'b0001, 1, 4'b0001, 1, 0, 10};
        vecs[1]  = '{4'b0010, 16'hFF3F, -1, -1, 4'b0010, 1, 4'b0010, 1, 0, 26};
        vecs[2]  = '{4'b0001, 16'hFFF0, -1, -1, 4'b0001, 1, 4'b0001, 1, 0, 10};
        vecs[3]  = '{4'b0100, 16'hF2FF,  3, -1, 4'b0100, 1, 4'b0000, 0, 1,  5};
        vecs[4]  = '{4'b1001, 16'h2FF7, -1, -1, 4'b1000, 1, 4'b1000, 1, 0, 18};
        vecs[5]  = '{4'b1001, 16'h7FF2, -1, -1, 4'b0001, 1, 4'b0001, 1, 0, 18};
        vecs[6]  = '{4'b0001, 16'hFFF1,  8, -1, 4'b0001, 1, 4'b0001, 1, 0, 10};
        vecs[7]  = '{4'b1000, 16'h2FFF,  8, -1, 4'b1000, 1, 4'b0000, 0, 1, 10};
        vecs[8]  = '{4'b0010, 16'hFF1F, -1,  0, 4'b0010, 1, 4'b0010, 1, 0, 10};
        vecs[9]  = '{4'b0100, 16'hF2FF, -1,  3, 4'b0100, 1, 4'b0100, 1, 0, 10};
        vecs[10] = '{4'b0001, 16'hFFF1, -1,  9, 4'b0001, 1, 4'b0001, 1, 0, 10};
        fresh    = '{4'b0001, 16'hFFF1, -1, -1, 4'b0001, 1, 4'b0001, 1, 0, 10};
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        #12;
        chk("rst_gnt",  32'(bus.GNT),     32'd0);
        chk("rst_done", 32'(bus.DONE),    32'd0);
        chk("rst_trg",  32'(bus.TRG_ONE), 32'd0);
        chk("rst_tmr",  32'(bus.TMR_R),   32'd0);
        chk("rst_busy", 32'(bus.BUSY),    32'd0);
        chk("mode",     32'(bus.MODE),    32'd1);
        @(negedge CLK);
        R_N = 1'b1;

        for (int i = 0; i < 11; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset in the middle of a long WAIT.
        @(negedge CLK);
        bus.REQ = 4'b0001;
        bus.CNT = 16'hFFF5;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge CLK);
            if (bus.GNT !== 4'b0000) got = 1'b1;
        end
        chk("mid_granted", 32'(got), 32'd1);
        repeat (4) @(negedge CLK);
        chk("mid_busy", 32'(bus.BUSY), 32'd1);
        R_N = 1'b0;
        bus.REQ = '0;
        #1;
        chk("mid_rst_outs", 32'({bus.GNT, bus.DONE, bus.TRG_ONE, bus.TMR_R, bus.BUSY}), 32'd0);
        @(negedge CLK);
        R_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_idle", 32'({bus.BUSY, bus.DONE}), 32'd0);
        run_vec("fresh", fresh);

        // Round-robin with everyone requesting, starting from reset state.
        @(negedge CLK);
        R_N = 1'b0;
        @(negedge CLK);
        R_N = 1'b1;
        bus.REQ = 4'b1111;
        bus.CNT = 16'h1111;
        prev_g  = '0;
        k       = 0;
        overlap = 1'b0;
        for (int c = 0; c < 200 && k < 5; c++) begin
            @(negedge CLK);
            if ($countones(bus.GNT) > 1) overlap = 1'b1;
            if (bus.GNT !== 4'b0000 && prev_g === 4'b0000) begin
                chk($sformatf("rr_grant%0d", k), 32'(bus.GNT), 32'(rr_exp[k]));
                k++;
            end
            prev_g = bus.GNT;
        end
        chk("rr_count",   32'(k),       32'd5);
        chk("rr_overlap", 32'(overlap), 32'd0);
        bus.REQ = '0;
        for (int c = 0; c < 40 && bus.BUSY === 1'b1; c++) @(negedge CLK);
        chk("rr_end_idle", 32'(bus.BUSY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
